multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multicycle control FSM for the RV32I-subset core. It sequences one shared ALU, one unified instruction/data memory and the register file through fetch, decode, execute, memory and writeback steps. It decodes opcode and func3 itself and drives every datapath enable and mux select. It stalls on a memory ready handshake.

## Interface
Parameters:
- INSTR_WIDTH, 32, instruction width.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr_i  in  INSTR_WIDTH  instruction register contents.
- zero_i  in  1  ALU zero flag; valid in the BRANCH state.
- mem_ready_i  in  1  memory completes the current access this cycle.
- PCWrite_o  out  1  PC load enable.
- AdrSrc_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead_o  out  1  memory read request.
- MemWrite_o  out  1  memory write request.
- IRWrite_o  out  1  IR and OldPC load enable.
- ByteOp_o  out  1  byte access (lb/sb).
- ResultSrc_o  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
- ALUSrcA_o  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB_o  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = const 4.
- ALUControl_o  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc_o  out  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J.
- RegWrite_o  out  1  register file write enable.
- fault_o  out  1  illegal opcode detected; sticky until rst.

## Operation
- Supported opcodes:
  - 0110011 R
  - 0010011 I-ALU
  - 0000011 load
  - 0100011 store
  - 1100011 branch (beq, bne)
  - 1101111 jal
  - 1100111 jalr
  - 0110111 lui
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JALRADR, JUMP, LUI, FAULT.
- FETCH: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - When mem_ready_i=1: IRWrite=1, PCWrite=1 (PC<=PC+4), go to DECODE.
  - Otherwise stay in FETCH with all enables 0.
- DECODE: ALUSrcA=01, ALUSrcB=01, add, ImmSrc=B or J per opcode. ALUOut becomes the branch/jump target.
  - Next state by opcode: load/store→MEMADR, R→EXECR, I-ALU→EXECI, branch→BRANCH, jal→JUMP, jalr→JALRADR, lui→LUI.
  - Any other opcode→FAULT.
- MEMADR: A=10, B=01, add, ImmSrc I (load) or S (store). Go to MEMREAD for load, MEMWRITE for store.
- MEMREAD: MemRead=1, AdrSrc=1; wait for mem_ready_i, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: MemWrite=1, AdrSrc=1; wait for mem_ready_i, then FETCH.
- ByteOp_o=1 in MEMADR, MEMREAD, MEMWB and MEMWRITE when func3=000; otherwise 0.
- EXECR: A=10, B=00. ALUControl from func3/func7:
  - 000 with func7[5]=0 → add
  - 000 with func7[5]=1 → sub
  - 111 → and
  - 110 → or
  - 010 → slt
  - Other func3 values → FAULT.
- EXECI: A=10, B=01, ImmSrc I, same func3 map; func7 is ignored (addi never subtracts).
- EXECR and EXECI go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: A=10, B=00, sub, ResultSrc=00.
  - PCWrite = zero_i for func3=000, !zero_i for func3=001.
  - Other func3 → FAULT. Otherwise go to FETCH.
- JALRADR: A=10, B=01, ImmSrc I, add, then JUMP.
- JUMP: PCWrite=1, ResultSrc=00 (target), A=01, B=10, add (ALUOut<=OldPC+4), then ALUWB.
- LUI: ImmSrc U, ResultSrc=11, RegWrite=1, then FETCH.
- FAULT: all enables 0, fault_o=1; held until rst.

## Timing
- rst samples on the clock edge. Next state is FETCH, fault_o=0.
- Outputs are a Moore decode of the registered state, except:
  - IRWrite/PCWrite in FETCH are gated by mem_ready_i.
  - PCWrite in BRANCH is gated by zero_i.
- While rst=1 all write enables (PCWrite, IRWrite, MemWrite, RegWrite) are forced to 0, regardless of state.
- rst mid-access (waiting in MEMREAD/MEMWRITE/FETCH) abandons the access; no write enable fires that cycle.
- mem_ready_i is ignored outside FETCH, MEMREAD and MEMWRITE.
- mem_ready_i held low stalls indefinitely with request outputs held stable.
- Cycles per instruction with zero-wait memory:
  - lui 3
  - branch 3
  - R/I 4
  - jal 4
  - store 4
  - load 5
  - jalr 5
- Each wait cycle on mem_ready_i adds one cycle.

## Structure
- Shared package `riscv_pkg`:
  - opcode localparams.
  - state_t enum.
  - ALUControl, ResultSrc, ALUSrcA/B and ImmSrc encodings, shared with the datapath.
- One sub-module, `seq_alu_decode`: combinational func3/func7 → ALUControl plus illegal flag.
- State register and next-state/output logic stay in `multicycle_sequencer`.

## Test plan
- Reset then add x3,x1,x2 (0x002081B3), mem_ready_i=1:
  - FETCH, DECODE, EXECR, ALUWB.
  - ALUControl=000 in EXECR; RegWrite=1 only in cycle 4.
- lw (0x0000A183) with mem_ready_i low for 3 cycles in MEMREAD:
  - State is held and MemRead stays 1.
  - MEMWB follows one cycle after ready; 8 cycles total.
- beq (0x00208463):
  - zero_i=1 gives PCWrite=1 in BRANCH.
  - Repeat with zero_i=0: PCWrite=0 and the next state is FETCH.
- jal (0x008000EF):
  - JUMP has PCWrite=1, ResultSrc=00.
  - ALUWB has RegWrite=1, ResultSrc=00.
- Opcode 0x7F:
  - FAULT with fault_o=1, held for 20 cycles.
  - rst for one cycle gives FETCH and fault_o=0.
- rst asserted during MEMWRITE wait:
  - MemWrite=0 on the reset cycle.
  - Next state is FETCH.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode, FSM state and datapath select encodings shared by the RV32I-subset core
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALRADR  = 4'd10,
    S_JUMP     = 4'd11,
    S_LUI      = 4'd12,
    S_FAULT    = 4'd13
  } state_t;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMM       = 2'b11;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  function automatic state_t decode_next(input logic [6:0] op);
    return (op == OP_LOAD || op == OP_STORE) ? S_MEMADR :
           op == OP_R      ? S_EXECR   :
           op == OP_I      ? S_EXECI   :
           op == OP_BRANCH ? S_BRANCH  :
           op == OP_JAL    ? S_JUMP    :
           op == OP_JALR   ? S_JALRADR :
           op == OP_LUI    ? S_LUI     : S_FAULT;
  endfunction
endpackage

// File: rtl/seq_alu_decode.sv
// seq_alu_decode: func3/func7 to ALUControl, flagging func3 values the core does not implement
module seq_alu_decode
  import riscv_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       func7_5,
  input  logic       sub_en,
  output logic [2:0] alu_control,
  output logic       illegal
);
  // sub_en is only set for register-register ops so addi never subtracts
  always_comb begin
    alu_control = func3 == 3'b000 ? ((sub_en && func7_5) ? ALU_SUB : ALU_ADD) :
                  func3 == 3'b111 ? ALU_AND :
                  func3 == 3'b110 ? ALU_OR  :
                  func3 == 3'b010 ? ALU_SLT : ALU_ADD;
    illegal = !(func3 inside {3'b000, 3'b111, 3'b110, 3'b010});
  end
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: control FSM sequencing fetch/decode/execute/memory/writeback for the multicycle core
module multicycle_sequencer
  import riscv_pkg::*;
#(
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic                   zero_i,
  input  logic                   mem_ready_i,
  output logic                   PCWrite_o,
  output logic                   AdrSrc_o,
  output logic                   MemRead_o,
  output logic                   MemWrite_o,
  output logic                   IRWrite_o,
  output logic                   ByteOp_o,
  output logic [1:0]             ResultSrc_o,
  output logic [1:0]             ALUSrcA_o,
  output logic [1:0]             ALUSrcB_o,
  output logic [2:0]             ALUControl_o,
  output logic [2:0]             ImmSrc_o,
  output logic                   RegWrite_o,
  output logic                   fault_o
);
  state_t     state, state_nxt;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [2:0] alu_dec;
  logic       alu_illegal;
  logic       pc_w, ir_w, mem_w, reg_w;
  logic       unused_bits;
  assign opcode      = instr_i[6:0];
  assign func3       = instr_i[14:12];
  assign unused_bits = ^{instr_i[INSTR_WIDTH-1:31], instr_i[29:15], instr_i[11:7]};
  seq_alu_decode u_alu_decode (
    .func3       (func3),
    .func7_5     (instr_i[30]),
    .sub_en      (state == S_EXECR),
    .alu_control (alu_dec),
    .illegal     (alu_illegal)
  );
  always_ff @(posedge clk) begin
    state <= rst ? S_FETCH : state_nxt;
  end
  always_comb begin
    state_nxt    = state;
    pc_w         = 1'b0;
    ir_w         = 1'b0;
    mem_w        = 1'b0;
    reg_w        = 1'b0;
    MemRead_o    = 1'b0;
    AdrSrc_o     = 1'b0;
    ResultSrc_o  = RES_ALUOUT;
    ALUSrcA_o    = SRCA_PC;
    ALUSrcB_o    = SRCB_RD2;
    ALUControl_o = ALU_ADD;
    ImmSrc_o     = IMM_I;
    case (state)
      S_FETCH: begin
        MemRead_o   = 1'b1;
        ALUSrcB_o   = SRCB_FOUR;
        ResultSrc_o = RES_ALURESULT;
        pc_w        = mem_ready_i;
        ir_w        = mem_ready_i;
        state_nxt   = mem_ready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_IMM;
        ImmSrc_o  = opcode == OP_JAL ? IMM_J : IMM_B;
        state_nxt = decode_next(opcode);
      end
      S_MEMADR: begin
        ALUSrcA_o = SRCA_RD1;
        ALUSrcB_o = SRCB_IMM;
        ImmSrc_o  = opcode == OP_STORE ? IMM_S : IMM_I;
        state_nxt = opcode == OP_STORE ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemRead_o = 1'b1;
        AdrSrc_o  = 1'b1;
        state_nxt = mem_ready_i ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc_o = RES_DATA;
        reg_w       = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_w     = 1'b1;
        AdrSrc_o  = 1'b1;
        state_nxt = mem_ready_i ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA_o    = SRCA_RD1;
        ALUSrcB_o    = state == S_EXECI ? SRCB_IMM : SRCB_RD2;
        ALUControl_o = alu_dec;
        state_nxt    = alu_illegal ? S_FAULT : S_ALUWB;
      end
      S_ALUWB: begin
        reg_w     = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o    = SRCA_RD1;
        ALUControl_o = ALU_SUB;
        pc_w         = func3 == 3'b000 ? zero_i : func3 == 3'b001 ? !zero_i : 1'b0;
        state_nxt    = func3[2:1] == 2'b00 ? S_FETCH : S_FAULT;
      end
      S_JALRADR: begin
        ALUSrcA_o = SRCA_RD1;
        ALUSrcB_o = SRCB_IMM;
        state_nxt = S_JUMP;
      end
      S_JUMP: begin
        pc_w      = 1'b1;
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_FOUR;
        state_nxt = S_ALUWB;
      end
      S_LUI: begin
        ImmSrc_o    = IMM_U;
        ResultSrc_o = RES_IMM;
        reg_w       = 1'b1;
        state_nxt   = S_FETCH;
      end
      default: state_nxt = S_FAULT;
    endcase
  end
  // reset abandons any in-flight access: no architectural write may fire while rst is high
  assign PCWrite_o  = pc_w && !rst;
  assign IRWrite_o  = ir_w && !rst;
  assign MemWrite_o = mem_w && !rst;
  assign RegWrite_o = reg_w && !rst;
  assign ByteOp_o   = (state inside {S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE}) && func3 == 3'b000;
  assign fault_o    = state == S_FAULT;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: scoreboard bench, per-cycle expectations from an instruction-level timing model
module tb_multicycle_sequencer;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
  typedef struct {
    logic [3:0] wen;
    bit         cm;
    logic       mr;
    bit         cr;
    logic [1:0] res;
    bit         ca;
    logic [2:0] alu;
    bit         cb;
    logic       bop;
    bit         cf;
    logic       flt;
    int         tag;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst, zero, ready;
  logic [31:0] instr;
  logic        pc_write, adr_src, mem_read, mem_write, ir_write, byte_op, reg_write, fault;
  logic [1:0]  result_src, src_a, src_b;
  logic [2:0]  alu_control, imm_src;
  exp_t        q[$];
  exp_t        m_e;
  int          vectors = 0, miscompares = 0, tag = 0;
  multicycle_sequencer #(.INSTR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr_i(instr), .zero_i(zero), .mem_ready_i(ready),
    .PCWrite_o(pc_write), .AdrSrc_o(adr_src), .MemRead_o(mem_read), .MemWrite_o(mem_write),
    .IRWrite_o(ir_write), .ByteOp_o(byte_op), .ResultSrc_o(result_src), .ALUSrcA_o(src_a),
    .ALUSrcB_o(src_b), .ALUControl_o(alu_control), .ImmSrc_o(imm_src), .RegWrite_o(reg_write),
    .fault_o(fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int t, input logic [3:0] got, input logic [3:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s instr#%0d got=%b expected=%b at %0t", n, t, got, want, $time);
    end
  endtask
  always @(negedge clk) if (q.size() > 0) begin
    m_e = q.pop_front();
    vectors++;
    chk("write_enables{PC,IR,Mem,Reg}", m_e.tag, {pc_write, ir_write, mem_write, reg_write}, m_e.wen);
    if (m_e.cm) chk("MemRead", m_e.tag, {3'b0, mem_read}, {3'b0, m_e.mr});
    if (m_e.cr) chk("ResultSrc", m_e.tag, {2'b0, result_src}, {2'b0, m_e.res});
    if (m_e.ca) chk("ALUControl", m_e.tag, {1'b0, alu_control}, {1'b0, m_e.alu});
    if (m_e.cb) chk("ByteOp", m_e.tag, {3'b0, byte_op}, {3'b0, m_e.bop});
    if (m_e.cf) chk("fault", m_e.tag, {3'b0, fault}, {3'b0, m_e.flt});
  end
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic exp_t base();
    exp_t e;
    e.wen = 4'b0; e.cm = 1; e.mr = 0; e.cr = 0; e.res = 2'b0; e.ca = 0; e.alu = 3'b0;
    e.cb = 0; e.bop = 0; e.cf = 1; e.flt = 0; e.tag = tag;
    return e;
  endfunction
  task automatic cyc(input logic r, input logic rdy, input logic z, input logic [31:0] ins, input exp_t e);
    rst = r; ready = rdy; zero = z; instr = ins;
    q.push_back(e);
    @(posedge clk); #1;
  endtask
  task automatic wb(input logic [31:0] ins, input logic [1:0] res);
    exp_t e;
    e = base(); e.wen = 4'b0001; e.cr = 1; e.res = res;
    cyc(0, rb(), rb(), ins, e);
  endtask
  task automatic fault_hold(input int hold);
    exp_t e;
    for (int i = 0; i < hold; i++) begin
      e = base(); e.flt = 1;
      cyc(0, rb(), rb(), $urandom, e);
    end
    e = base(); e.flt = 1;
    cyc(1, rb(), rb(), $urandom, e);
  endtask
  task automatic jump(input logic [31:0] ins);
    exp_t e;
    e = base(); e.wen = 4'b1000; e.cr = 1; e.res = 2'b00; e.ca = 1; e.alu = 3'b000;
    cyc(0, rb(), rb(), ins, e);
    wb(ins, 2'b00);
  endtask
  // one instruction: fetch waits wf, memory waits wm, optional rst on the last memory wait
  task automatic run(input logic [31:0] ins, input int wf, input int wm, input bit abort, input int hold, input int zsel);
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    bit         ok, ld;
    op = ins[6:0];
    f3 = ins[14:12];
    tag++;
    for (int i = 0; i < wf; i++) begin
      e = base(); e.mr = 1;
      cyc(0, 0, rb(), $urandom, e);
    end
    e = base(); e.mr = 1; e.wen = 4'b1100; e.cr = 1; e.res = 2'b10; e.ca = 1; e.alu = 3'b000;
    cyc(0, 1, rb(), $urandom, e);
    e = base(); e.ca = 1; e.alu = 3'b000;
    cyc(0, rb(), rb(), ins, e);
    if (op == OP_R || op == OP_I) begin
      ok = f3 inside {3'b000, 3'b111, 3'b110, 3'b010};
      e = base(); e.ca = ok;
      e.alu = f3 == 3'b111 ? 3'b010 : f3 == 3'b110 ? 3'b011 : f3 == 3'b010 ? 3'b101 :
              (op == OP_R && ins[30]) ? 3'b001 : 3'b000;
      cyc(0, rb(), rb(), ins, e);
      if (ok) wb(ins, 2'b00);
      else fault_hold(hold);
    end else if (op == OP_LD || op == OP_ST) begin
      ld = op == OP_LD;
      e = base(); e.cb = 1; e.bop = f3 == 3'b000; e.ca = 1; e.alu = 3'b000;
      cyc(0, rb(), rb(), ins, e);
      for (int i = 0; i <= wm; i++) begin
        e = base(); e.cb = 1; e.bop = f3 == 3'b000;
        if (ld) e.mr = 1;
        else e.wen = 4'b0010;
        if (abort && wm > 0 && i == wm - 1) begin
          e.wen = 4'b0000; e.cm = 0;
          cyc(1, rb(), rb(), ins, e);
          return;
        end
        cyc(0, i == wm, rb(), ins, e);
      end
      if (ld) begin
        e = base(); e.wen = 4'b0001; e.cr = 1; e.res = 2'b01; e.cb = 1; e.bop = f3 == 3'b000;
        cyc(0, rb(), rb(), ins, e);
      end
    end else if (op == OP_BR) begin
      ok = f3[2:1] == 2'b00;
      z = zsel < 0 ? rb() : zsel[0];
      e = base(); e.ca = 1; e.alu = 3'b001; e.cr = 1; e.res = 2'b00;
      e.wen = (ok && (f3[0] ? !z : z)) ? 4'b1000 : 4'b0000;
      cyc(0, rb(), z, ins, e);
      if (!ok) fault_hold(hold);
    end else if (op == OP_JAL) begin
      jump(ins);
    end else if (op == OP_JALR) begin
      e = base(); e.ca = 1; e.alu = 3'b000;
      cyc(0, rb(), rb(), ins, e);
      jump(ins);
    end else if (op == OP_LUI) begin
      wb(ins, 2'b11);
    end else begin
      fault_hold(hold);
    end
  endtask
  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[8];
    logic [2:0]  alu_f3[4];
    logic [31:0] ins;
    int          k;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI};
    alu_f3 = '{3'b000, 3'b111, 3'b110, 3'b010};
    ins = $urandom;
    k = $urandom_range(0, 8);
    ins[6:0] = k < 8 ? ops[k] : 7'b0001111;
    if ($urandom_range(0, 7) != 0) begin
      if (ins[6:0] == OP_BR) ins[14:12] = {2'b00, rb()};
      else if (ins[6:0] == OP_R || ins[6:0] == OP_I) ins[14:12] = alu_f3[$urandom_range(0, 3)];
    end
    return ins;
  endfunction
  initial begin
    exp_t e;
    int   wm;
    rst = 1; ready = 0; zero = 0; instr = 32'b0;
    @(posedge clk); #1;
    e = base(); e.cm = 0; e.cf = 0;
    cyc(1, 0, 0, 32'b0, e);
    e = base(); e.mr = 1;
    cyc(1, 1, 1, 32'b0, e);
    run(32'h002081B3, 0, 0, 0, 1, -1);
    run(32'h0000A183, 0, 3, 0, 1, -1);
    run(32'h00208463, 0, 0, 0, 1, 1);
    run(32'h00208463, 0, 0, 0, 1, 0);
    run(32'h008000EF, 0, 0, 0, 1, -1);
    run(32'h0000007F, 0, 0, 0, 20, -1);
    run(32'h0020A023, 1, 3, 1, 1, -1);
    run(32'h00008023, 2, 1, 0, 1, -1);
    for (int n = 0; n < 300; n++) begin
      wm = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0;
      run(rand_instr(), $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0, wm,
          wm > 0 && $urandom_range(0, 5) == 0, $urandom_range(1, 4), -1);
    end
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
